mux_2x1: RTL and testbench
==========================

Name: mux_2x1

Overview:
- Registered 2-to-1 selector: on each rising clock edge, output c captures input a when sel=0 and input b when sel=1.
- Leaf datapath element used wherever one of two equal-width operands must be steered to a single registered output.
- Default configuration is 1-bit data, matching the exhaustive 8-combination {a,b,sel} sweep.

Parameters:
- WIDTH, default 1: bit width of data inputs a, b and output c; legal range 1..64.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- a  input  WIDTH  data input selected when sel=0.
- b  input  WIDTH  data input selected when sel=1.
- sel  input  1  select: 0 chooses a, 1 chooses b.
- c  output  WIDTH  registered selected data.

Behaviour:
- Single register stage, c_q[WIDTH-1:0], driving c directly. No combinational path from any input to c.
- At each rising clk edge:
  - if rst=1: c_q <= 0 (all bits).
  - else if sel=0: c_q <= a.
  - else (sel=1): c_q <= b.
- Latency is exactly 1 clock from input sampling to c. Inputs stable across an edge appear on c immediately after that edge and hold until the next edge.
- Reset value of c is all-zeros.
- c is undefined from time zero until the first edge with rst=1, or until the first non-reset capture. The bench must assert rst for at least 1 cycle at start.
- rst has priority over sel, a and b. With rst=1, c is forced to 0 regardless of inputs.
- Reset mid-operation:
  - c clears at the edge where rst is sampled high and stays 0 while rst is held.
  - On the first edge with rst=0, c reloads from the currently selected input. No recovery bubble.
- Unselected input has no effect on c. Toggling a while sel=1, or b while sel=0, must not change c.
- sel and data changing in the same cycle: the values present at the edge are used together. No ordering dependency.
- Behaviour is purely per-bit. For WIDTH>1 each bit of c follows the same rule with the shared sel.
- No enable and no hold input: c updates every cycle.
- The block holds no other state.

Test Plan:
- Reset: drive a=1, b=1, sel=1, rst=1 for 2 edges -> c=0 after first edge, stays 0; release rst -> c=1 after next edge.
- Exhaustive 1-bit sweep: after reset, apply {a,b,sel}=0..7, one combination per cycle, and check c one edge later. Expected c for i=0..7 is 0,0,0,1,1,0,1,1.
- Unselected-input isolation: sel=0, a=1, toggle b 0/1 for 4 cycles -> c stays 1. Then sel=1, b=0, toggle a 0/1 for 4 cycles -> c stays 0.
- Latency: sel=0, a steps 0->1 between edges N and N+1 -> c=0 after edge N, c=1 after edge N+1, never earlier.
- Reset mid-stream: while streaming sel=1, b=1 (c=1), assert rst for 1 cycle -> c=0 for exactly that edge; deassert -> c=1 on the following edge.
- Wide instance WIDTH=8: a=8'hA5, b=8'h3C; sel=0 -> c=8'hA5; sel=1 -> c=8'h3C; rst -> c=8'h00.

Source files
------------

// File: rtl/mux_2x1.sv
// Registered 2-to-1 selector: c captures a (sel=0) or b (sel=1) on each rising clk edge.
// Single register stage; synchronous active-high reset clears c to zero.
module mux_2x1 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] c
);

    logic [WIDTH-1:0] r_c_q;

    // rst outranks sel and data; no enable, so the register reloads every cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_c_q <= '0;
        end else if (sel) begin
            r_c_q <= b;
        end else begin
            r_c_q <= a;
        end
    end

    assign c = r_c_q;

endmodule

// File: tb/tb_mux_2x1.sv
// Self-checking bench for mux_2x1: directed steps plus randomized traffic on a 1-bit and an 8-bit instance.
// Expected values come from the selector rule applied to the inputs present at each edge.
module tb_mux_2x1;

    logic       clk = 1'b0;
    logic       rst;
    logic       a;
    logic       b;
    logic       sel;
    logic [7:0] a_w;
    logic [7:0] b_w;
    logic       c;
    logic [7:0] c_w;

    int n_chk  = 0;
    int n_pass = 0;

    mux_2x1 #(.WIDTH(1)) u_dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .sel (sel),
        .c   (c)
    );

    mux_2x1 #(.WIDTH(8)) u_dut_w (
        .clk (clk),
        .rst (rst),
        .a   (a_w),
        .b   (b_w),
        .sel (sel),
        .c   (c_w)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic exp);
        n_chk++;
        assert (c === exp) n_pass++;
        else $error("FAIL %s: c=%b expected %b", tag, c, exp);
    endtask

    task automatic chk8(input string tag, input logic [7:0] exp);
        n_chk++;
        assert (c_w === exp) n_pass++;
        else $error("FAIL %s: c_w=%h expected %h", tag, c_w, exp);
    endtask

    // Behavioural model: what the output must hold after an edge with these inputs.
    function automatic logic [7:0] model(input logic r, input logic s,
                                         input logic [7:0] da, input logic [7:0] db);
        if (r) return 8'h00;
        return s ? db : da;
    endfunction

    initial begin
        logic       sweep_exp [8];
        logic [2:0] v;
        logic       r_rst, r_sel, r_a, r_b;
        logic [7:0] r_aw, r_bw;

        sweep_exp = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

        // Reset holds c at zero for two edges even with b=1 selected
        rst = 1'b1; a = 1'b1; b = 1'b1; sel = 1'b1; a_w = 8'hA5; b_w = 8'h3C;
        tick();
        chk1("reset_edge1", 1'b0);
        chk8("reset_w_edge1", 8'h00);
        tick();
        chk1("reset_edge2", 1'b0);
        rst = 1'b0;
        tick();
        chk1("reset_release", 1'b1);
        chk8("reset_release_w", 8'h3C);

        // Exhaustive {a,b,sel} sweep
        for (int i = 0; i < 8; i++) begin
            v   = 3'(i);
            a   = v[2];
            b   = v[1];
            sel = v[0];
            tick();
            chk1($sformatf("sweep_%0d", i), sweep_exp[i]);
        end

        // Unselected input isolation
        sel = 1'b0; a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b = 1'(i);
            tick();
            chk1($sformatf("iso_b_%0d", i), 1'b1);
        end
        sel = 1'b1; b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a = ~1'(i);
            tick();
            chk1($sformatf("iso_a_%0d", i), 1'b0);
        end

        // Latency: a step between edges must not reach c before the next edge
        sel = 1'b0; a = 1'b0;
        tick();
        chk1("lat_edgeN", 1'b0);
        a = 1'b1;
        #2;
        chk1("lat_no_early", 1'b0);
        @(posedge clk);
        #1;
        chk1("lat_edgeN1", 1'b1);

        // One-cycle reset in the middle of a b=1 stream
        sel = 1'b1; b = 1'b1;
        tick();
        chk1("mid_stream", 1'b1);
        rst = 1'b1;
        tick();
        chk1("mid_rst", 1'b0);
        rst = 1'b0;
        tick();
        chk1("mid_recover", 1'b1);

        // Wide instance
        a_w = 8'hA5; b_w = 8'h3C; sel = 1'b0;
        tick();
        chk8("wide_sel0", 8'hA5);
        sel = 1'b1;
        tick();
        chk8("wide_sel1", 8'h3C);
        rst = 1'b1;
        tick();
        chk8("wide_rst", 8'h00);
        rst = 1'b0;

        // Randomized traffic with occasional resets
        for (int i = 0; i < 200; i++) begin
            r_rst = ($urandom_range(0, 7) == 0);
            r_sel = 1'($urandom);
            r_a   = 1'($urandom);
            r_b   = 1'($urandom);
            r_aw  = 8'($urandom);
            r_bw  = 8'($urandom);
            rst = r_rst; sel = r_sel; a = r_a; b = r_b; a_w = r_aw; b_w = r_bw;
            tick();
            chk1($sformatf("rand_%0d", i), model(r_rst, r_sel, {7'b0, r_a}, {7'b0, r_b}) != 8'h00);
            chk8($sformatf("rand_w_%0d", i), model(r_rst, r_sel, r_aw, r_bw));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
